fifo_shift_line: RTL and testbench
==================================

// Module: fifo_shift_line
// PURPOSE
//  Parametrised synchronous single-clock FIFO for the video line-buffer path; successor to the fixed 8x1024 fifo_shift.
//  Adds a first-word-fall-through (FWFT) option, sticky overflow/underflow flags and a runtime "shift" mode.
//  In shift mode the FIFO is a programmable fixed-length delay line: output = input delayed by shift_len accepted writes.
// PARAMETERS
//  DATA_WIDTH       8    width of wr_data/rd_data (1..1152)
//  DEPTH_WIDTH      10   log2 of depth; DEPTH = 2**DEPTH_WIDTH words
//  FWFT             0    0 = standard read (data 1 cycle after rd_en); 1 = head word presented without rd_en
//  ALMOST_FULL_NUM  960  almost_full when level >= this
//  ALMOST_EMPTY_NUM 4    almost_empty when level <= this
// PORTS
//  clk             in   1              clock, all logic on rising edge
//  tb_rst          in   1              asynchronous, active-high reset
//  wr_en           in   1              write request
//  wr_data         in   DATA_WIDTH     write data
//  wr_full         out  1              level == DEPTH
//  almost_full     out  1              level >= ALMOST_FULL_NUM
//  wr_water_level  out  DEPTH_WIDTH+1  current level (words stored, not yet popped)
//  rd_en           in   1              read/pop request (ignored in shift mode)
//  rd_data         out  DATA_WIDTH     read data
//  rd_valid        out  1              rd_data carries a newly read word this cycle
//  rd_empty        out  1              no word available
//  almost_empty    out  1              level <= ALMOST_EMPTY_NUM
//  shift_mode      in   1              1 = delay-line mode (honoured only when FWFT=0; ignored if FWFT=1)
//  shift_len       in   DEPTH_WIDTH+1  delay length, legal 1..DEPTH
//  err_clr         in   1              clears overflow/underflow
//  overflow        out  1              sticky: write rejected
//  underflow       out  1              sticky: read rejected
// BEHAVIOUR
//  - Reset (async assert, sync release): pointers/level=0, rd_data=0, rd_valid=0, rd_empty=1, almost_empty=1,
//    wr_full=0, almost_full=0, overflow=0, underflow=0. Storage contents not reset.
//  - Pointers DEPTH_WIDTH+1 bits, wrap modulo 2*DEPTH; full/empty from level register, flags combinational from registers.
//  - pop = shift_mode ? ((level > shift_len) | (wr_en & level == shift_len)) : (rd_en & !rd_empty).
//  - push = wr_en & (!wr_full | pop). Write accepted at full only with a simultaneous pop.
//  - level_next = level + push - pop; push&pop leaves level unchanged; order strictly preserved.
//  - FWFT=0: popped word on rd_data one cycle after pop edge, rd_valid=1 for that one cycle; rd_data holds otherwise.
//  - FWFT=1: prefetch output register; rd_valid=1 whenever head word present, rd_empty=!rd_valid;
//    first write into empty FIFO visible on rd_data the following cycle; rd_en with rd_valid pops and advances.
//    Level counts the prefetched word.
//  - Simultaneous wr_en+rd_en at empty (FWFT=0): write accepted, read rejected -> underflow.
//  - overflow set on wr_en & !push; underflow set on rd_en & rd_empty & !shift_mode. Set beats err_clr same cycle.
//  - Shift mode: external rd_en ignored; level converges to shift_len (excess drained one word/cycle);
//    at steady state each write emits word written shift_len writes earlier, 1 cycle after that write.
//    shift_len/shift_mode changes take effect next cycle; stored data is never discarded.
//  - Reset mid-operation: all state returns to reset values immediately; no partial output after release.
// TESTING
//  1. Defaults, 1024 writes 0xFF down to 0x00 -> almost_full at level 960, wr_full at 1024; 1025th write sets overflow, level stays 1024.
//  2. 1024 reads -> rd_data 0xFF,0xFE,.. one cycle after each rd_en, rd_valid pulses; extra rd_en sets underflow, rd_data holds 0x00.
//  3. Level 5, wr_en+rd_en 10 cycles -> level stays 5, output order preserved; at level 0 both -> write only, underflow=1; err_clr clears.
//  4. shift_mode=1, shift_len=640, continuous writes 0,1,2.. -> first rd_valid 1 cycle after write #641 with rd_data=0; level holds 640.
//  5. FWFT=1, single write 0x5A -> next cycle rd_valid=1, rd_data=0x5A without rd_en; rd_en pops, rd_empty=1.
//  6. Assert tb_rst at level 300 mid-stream -> all outputs to reset values asynchronously; post-release write 0x11/read returns 0x11.

Source files
------------

// File: rtl/fifo_shift_line.sv
// fifo_shift_line: parametrised single-clock FIFO with optional first-word-fall-through
// output, sticky overflow/underflow flags and a programmable delay-line (shift) mode.
module fifo_shift_line #(
    parameter int unsigned DATA_WIDTH       = 8,
    parameter int unsigned DEPTH_WIDTH      = 10,
    parameter int unsigned FWFT             = 0,
    parameter int unsigned ALMOST_FULL_NUM  = 960,
    parameter int unsigned ALMOST_EMPTY_NUM = 4
) (
    input  logic                  clk,
    input  logic                  tb_rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_full,
    output logic                  almost_full,
    output logic [DEPTH_WIDTH:0]  wr_water_level,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_empty,
    output logic                  almost_empty,
    input  logic                  shift_mode,
    input  logic [DEPTH_WIDTH:0]  shift_len,
    input  logic                  err_clr,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int unsigned          DEPTH     = 2 ** DEPTH_WIDTH;
    localparam logic [DEPTH_WIDTH:0] DEPTH_LVL = (DEPTH_WIDTH+1)'(DEPTH);
    localparam logic [DEPTH_WIDTH:0] AF_LVL    = (DEPTH_WIDTH+1)'(ALMOST_FULL_NUM);
    localparam logic [DEPTH_WIDTH:0] AE_LVL    = (DEPTH_WIDTH+1)'(ALMOST_EMPTY_NUM);
    localparam logic [DEPTH_WIDTH:0] ONE_LVL   = (DEPTH_WIDTH+1)'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DEPTH_WIDTH:0] wr_ptr;
    logic [DEPTH_WIDTH:0] rd_ptr;
    logic [DEPTH_WIDTH:0] level;
    logic [DEPTH_WIDTH:0] mem_cnt;
    logic                 shift_on;
    logic                 pop;
    logic                 push;
    logic                 mem_we;
    logic                 load_mem;
    logic                 load_byp;
    logic                 valid_nxt;

    assign shift_on       = (FWFT == 0) ? shift_mode : 1'b0;
    assign wr_full        = (level == DEPTH_LVL);
    assign almost_full    = (level >= AF_LVL);
    assign almost_empty   = (level <= AE_LVL);
    assign rd_empty       = (FWFT != 0) ? ~rd_valid : (level == '0);
    assign wr_water_level = level;
    // In FWFT mode the level includes the word parked in the output register.
    assign mem_cnt        = (FWFT != 0) ? level - {{DEPTH_WIDTH{1'b0}}, rd_valid} : level;

    always_comb begin
        pop       = 1'b0;
        push      = 1'b0;
        mem_we    = 1'b0;
        load_mem  = 1'b0;
        load_byp  = 1'b0;
        valid_nxt = 1'b0;
        if (FWFT == 0) begin
            if (shift_on)
                pop = ~rd_empty & ((level > shift_len) | (wr_en & (level == shift_len)));
            else
                pop = rd_en & ~rd_empty;
            push      = wr_en & (~wr_full | pop);
            mem_we    = push;
            load_mem  = pop;
            valid_nxt = pop;
        end else begin
            pop       = rd_en & rd_valid;
            push      = wr_en & (~wr_full | pop);
            valid_nxt = rd_valid;
            if (~rd_valid | pop) begin
                // Refill the output register from storage, or bypass the write when storage is empty.
                if (mem_cnt != '0) begin
                    load_mem  = 1'b1;
                    mem_we    = push;
                    valid_nxt = 1'b1;
                end else begin
                    load_byp  = push;
                    valid_nxt = push;
                end
            end else begin
                mem_we = push;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we)
            mem[wr_ptr[DEPTH_WIDTH-1:0]] <= wr_data;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (mem_we)
                wr_ptr <= wr_ptr + ONE_LVL;
            if (load_mem) begin
                rd_data <= mem[rd_ptr[DEPTH_WIDTH-1:0]];
                rd_ptr  <= rd_ptr + ONE_LVL;
            end else if (load_byp) begin
                rd_data <= wr_data;
            end
            rd_valid <= valid_nxt;
            if (push && !pop)
                level <= level + ONE_LVL;
            else if (pop && !push)
                level <= level - ONE_LVL;
            if (wr_en && !push)
                overflow <= 1'b1;
            else if (err_clr)
                overflow <= 1'b0;
            if (rd_en && rd_empty && !shift_on)
                underflow <= 1'b1;
            else if (err_clr)
                underflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_fifo_shift_line.sv
// Randomised scoreboard bench for fifo_shift_line: a standard-read instance with default
// parameters and a small FWFT instance, both checked against queue-based reference models.
module tb_fifo_shift_line;
    localparam int unsigned DW      = 8;
    localparam int unsigned AW      = 10;
    localparam int unsigned DEPTH   = 1024;
    localparam int unsigned F_AW    = 4;
    localparam int unsigned F_DEPTH = 16;

    logic clk = 1'b0;
    logic tb_rst;

    logic          wr_en, rd_en, shift_mode, err_clr;
    logic [DW-1:0] wr_data, rd_data;
    logic [AW:0]   shift_len, wr_water_level;
    logic          wr_full, almost_full, rd_valid, rd_empty, almost_empty, overflow, underflow;

    logic          f_wr_en, f_rd_en, f_err_clr;
    logic [DW-1:0] f_wr_data, f_rd_data;
    logic [F_AW:0] f_shift_len, f_level;
    logic          f_full, f_afull, f_rd_valid, f_rd_empty, f_aempty, f_ovf_o, f_udf_o;

    typedef struct {
        int            cyc;
        logic [DW-1:0] d;
    } exp_t;

    logic [DW-1:0] m_q[$];
    logic [DW-1:0] f_q[$];
    exp_t          exp_q[$];
    logic [DW-1:0] m_last;
    logic          m_ovf, m_udf, f_ovf, f_udf;
    int            cyc = 0;
    int            checks = 0;
    int            errors = 0;

    fifo_shift_line #(.DATA_WIDTH(DW), .DEPTH_WIDTH(AW), .FWFT(0),
                      .ALMOST_FULL_NUM(960), .ALMOST_EMPTY_NUM(4)) dut (
        .clk(clk), .tb_rst(tb_rst), .wr_en(wr_en), .wr_data(wr_data), .wr_full(wr_full),
        .almost_full(almost_full), .wr_water_level(wr_water_level), .rd_en(rd_en),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_empty(rd_empty), .almost_empty(almost_empty),
        .shift_mode(shift_mode), .shift_len(shift_len), .err_clr(err_clr),
        .overflow(overflow), .underflow(underflow));

    fifo_shift_line #(.DATA_WIDTH(DW), .DEPTH_WIDTH(F_AW), .FWFT(1),
                      .ALMOST_FULL_NUM(12), .ALMOST_EMPTY_NUM(2)) dut_f (
        .clk(clk), .tb_rst(tb_rst), .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_full(f_full),
        .almost_full(f_afull), .wr_water_level(f_level), .rd_en(f_rd_en),
        .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty), .almost_empty(f_aempty),
        .shift_mode(shift_mode), .shift_len(f_shift_len), .err_clr(f_err_clr),
        .overflow(f_ovf_o), .underflow(f_udf_o));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_models();
        m_q.delete();
        f_q.delete();
        exp_q.delete();
        m_last = '0;
        m_ovf = 1'b0; m_udf = 1'b0; f_ovf = 1'b0; f_udf = 1'b0;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; err_clr = 1'b0;
        f_wr_en = 1'b0; f_rd_en = 1'b0; f_err_clr = 1'b0;
    endtask

    // Applies the current inputs to both reference models for the coming clock edge.
    task automatic model_update();
        int sz, fsz;
        logic pop, push, fpop, fpush;
        logic [DW-1:0] d;
        exp_t e;
        sz = m_q.size();
        if (shift_mode)
            pop = (sz != 0) && ((sz > int'(shift_len)) || (wr_en && sz == int'(shift_len)));
        else
            pop = rd_en && (sz != 0);
        push = wr_en && ((sz != DEPTH) || pop);
        if (pop) begin
            d = m_q.pop_front();
            e.cyc = cyc + 1;
            e.d = d;
            exp_q.push_back(e);
            m_last = d;
        end
        if (push) m_q.push_back(wr_data);
        if (wr_en && !push) m_ovf = 1'b1; else if (err_clr) m_ovf = 1'b0;
        if (rd_en && sz == 0 && !shift_mode) m_udf = 1'b1; else if (err_clr) m_udf = 1'b0;

        fsz = f_q.size();
        fpop = f_rd_en && (fsz != 0);
        fpush = f_wr_en && ((fsz != F_DEPTH) || fpop);
        if (fpop) void'(f_q.pop_front());
        if (fpush) f_q.push_back(f_wr_data);
        if (f_wr_en && !fpush) f_ovf = 1'b1; else if (f_err_clr) f_ovf = 1'b0;
        if (f_rd_en && fsz == 0) f_udf = 1'b1; else if (f_err_clr) f_udf = 1'b0;
    endtask

    task automatic check_status();
        int sz, fsz;
        sz = m_q.size();
        fsz = f_q.size();
        chk("level", 64'(wr_water_level), 64'(sz));
        chk("wr_full", 64'(wr_full), 64'(sz == DEPTH));
        chk("almost_full", 64'(almost_full), 64'(sz >= 960));
        chk("almost_empty", 64'(almost_empty), 64'(sz <= 4));
        chk("rd_empty", 64'(rd_empty), 64'(sz == 0));
        chk("overflow", 64'(overflow), 64'(m_ovf));
        chk("underflow", 64'(underflow), 64'(m_udf));
        chk("rd_data_hold", 64'(rd_data), 64'(m_last));
        chk("f_level", 64'(f_level), 64'(fsz));
        chk("f_wr_full", 64'(f_full), 64'(fsz == F_DEPTH));
        chk("f_almost_full", 64'(f_afull), 64'(fsz >= 12));
        chk("f_almost_empty", 64'(f_aempty), 64'(fsz <= 2));
        chk("f_rd_empty", 64'(f_rd_empty), 64'(fsz == 0));
        chk("f_rd_valid", 64'(f_rd_valid), 64'(fsz != 0));
        chk("f_overflow", 64'(f_ovf_o), 64'(f_ovf));
        chk("f_underflow", 64'(f_udf_o), 64'(f_udf));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_level"}, 64'(wr_water_level), 64'd0);
        chk({tag, "_rd_data"}, 64'(rd_data), 64'd0);
        chk({tag, "_rd_valid"}, 64'(rd_valid), 64'd0);
        chk({tag, "_rd_empty"}, 64'(rd_empty), 64'd1);
        chk({tag, "_almost_empty"}, 64'(almost_empty), 64'd1);
        chk({tag, "_wr_full"}, 64'(wr_full), 64'd0);
        chk({tag, "_almost_full"}, 64'(almost_full), 64'd0);
        chk({tag, "_overflow"}, 64'(overflow), 64'd0);
        chk({tag, "_underflow"}, 64'(underflow), 64'd0);
        chk({tag, "_f_level"}, 64'(f_level), 64'd0);
        chk({tag, "_f_rd_valid"}, 64'(f_rd_valid), 64'd0);
        chk({tag, "_f_rd_empty"}, 64'(f_rd_empty), 64'd1);
    endtask

    task automatic step();
        model_update();
        @(negedge clk);
        #1;
        check_status();
    endtask

    // Scoreboard monitor: pops an expectation whenever one is due and compares the DUT output.
    always @(negedge clk) begin
        logic ev;
        exp_t e;
        if (!tb_rst) begin
            ev = 1'b0;
            e.cyc = 0;
            e.d = '0;
            if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
                ev = 1'b1;
                e = exp_q.pop_front();
            end
            chk("rd_valid", 64'(rd_valid), 64'(ev));
            if (ev && rd_valid) chk("rd_data", 64'(rd_data), 64'(e.d));
            if (f_rd_valid && f_q.size() != 0) chk("f_rd_data", 64'(f_rd_data), 64'(f_q[0]));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        shift_mode = 1'b0;
        shift_len = 11'd1;
        f_shift_len = 5'd3;
        wr_data = '0;
        f_wr_data = '0;
        clear_models();
        tb_rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_reset("por");
        tb_rst = 1'b0;
        step();

        // Fill to full, then one rejected write.
        for (int i = 0; i < 1024; i++) begin
            wr_en = 1'b1;
            wr_data = DW'(255 - i);
            step();
        end
        wr_data = 8'hAA;
        step();
        chk("t1_overflow", 64'(overflow), 64'd1);
        chk("t1_level", 64'(wr_water_level), 64'd1024);
        idle();

        // Drain everything, then one rejected read.
        for (int i = 0; i < 1025; i++) begin
            rd_en = 1'b1;
            step();
        end
        chk("t2_underflow", 64'(underflow), 64'd1);
        chk("t2_rd_data", 64'(rd_data), 64'h00);
        idle();
        err_clr = 1'b1;
        step();
        idle();

        // Concurrent read/write at level 5, then both at empty.
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; wr_data = DW'($urandom); step();
        end
        for (int i = 0; i < 10; i++) begin
            wr_en = 1'b1; rd_en = 1'b1; wr_data = DW'($urandom); step();
        end
        chk("t3_level", 64'(wr_water_level), 64'd5);
        wr_en = 1'b0;
        for (int i = 0; i < 5; i++) step();
        wr_en = 1'b1; wr_data = DW'($urandom);
        step();
        chk("t3_underflow", 64'(underflow), 64'd1);
        chk("t3_level1", 64'(wr_water_level), 64'd1);
        idle();
        err_clr = 1'b1;
        step();
        idle();
        rd_en = 1'b1;
        step();
        idle();

        // Delay-line mode.
        shift_mode = 1'b1;
        shift_len = 11'd640;
        for (int i = 0; i < 900; i++) begin
            wr_en = 1'b1; wr_data = DW'(i); step();
        end
        chk("t4_level", 64'(wr_water_level), 64'd640);
        idle();
        shift_len = 11'd600;
        for (int i = 0; i < 50; i++) step();
        chk("t4_level_shrunk", 64'(wr_water_level), 64'd600);
        shift_mode = 1'b0;
        rd_en = 1'b1;
        for (int i = 0; i < 600; i++) step();
        idle();

        // FWFT single word.
        f_wr_en = 1'b1; f_wr_data = 8'h5A;
        step();
        idle();
        chk("t5_f_valid", 64'(f_rd_valid), 64'd1);
        chk("t5_f_data", 64'(f_rd_data), 64'h5A);
        f_rd_en = 1'b1;
        step();
        idle();
        chk("t5_f_empty", 64'(f_rd_empty), 64'd1);

        // Randomised mixed traffic on both instances.
        for (int i = 0; i < 3000; i++) begin
            int pw;
            pw = (i < 1500) ? 65 : 40;
            if ($urandom_range(0, 99) < 3) begin
                shift_mode = ~shift_mode;
                shift_len = AW'($urandom_range(1, 40));
            end
            wr_en = ($urandom_range(0, 99) < 55);
            rd_en = ($urandom_range(0, 99) < 50);
            wr_data = DW'($urandom);
            err_clr = ($urandom_range(0, 49) == 0);
            f_wr_en = ($urandom_range(0, 99) < pw);
            f_rd_en = ($urandom_range(0, 99) < 50);
            f_wr_data = DW'($urandom);
            f_err_clr = ($urandom_range(0, 49) == 0);
            step();
        end
        idle();
        shift_mode = 1'b0;
        step();

        // Asynchronous reset in the middle of a write stream.
        for (int k = 0; k < 1024 && m_q.size() < 300; k++) begin
            wr_en = 1'b1; wr_data = DW'($urandom); f_wr_en = 1'b1; f_wr_data = DW'($urandom);
            step();
        end
        chk("t6_level_pre", 64'(wr_water_level), 64'd300);
        #2;
        tb_rst = 1'b1;
        #1;
        clear_models();
        check_reset("mid");
        idle();
        @(negedge clk);
        #1;
        check_reset("held");
        tb_rst = 1'b0;
        step();
        wr_en = 1'b1; wr_data = 8'h11;
        step();
        idle();
        rd_en = 1'b1;
        step();
        idle();
        chk("t6_rd_data", 64'(rd_data), 64'h11);
        repeat (3) step();
        chk("exp_drained", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
